alu_param_core: RTL

// - Parametrised successor to the 8-bit HAVEN ALU DUT, driven by the GA/UVM environment.
// - Width is generic. MULT is multicycle with configurable latency. Operand B source is

---
 rtl/alu_param_core_if.sv | 56 +++++
 rtl/alu_param_core.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_param_core_if.sv
// -----------------------------------------------------------------------------
// alu_param_core_if
// Request/result bundle between an ALU requester and alu_param_core.
//
// Handshake: a request is taken on a rising CLK edge where ACT=1 and
// ALU_RDY=1. All request fields (OP, MOVI, REG_A, REG_B, MEM, IMM) are
// sampled on that same edge. ACT while ALU_RDY=0 is dropped, not queued.
// EX_ALU_VLD is a one-cycle pulse meaning EX_ALU holds a new result. There
// is no result back-pressure.
//
// Signals:
//   ACT         request strobe (master -> core)
//   OP          4-bit opcode
//   MOVI        operand B select: 0=REG_B, 1=MEM, 2=IMM, 3=REG_B
//   REG_A       operand A
//   REG_B/MEM/IMM  operand B candidates
//   ALU_RDY     core can accept ACT this cycle (core -> master)
//   EX_ALU      result, held until the next result
//   EX_ALU_VLD  one-cycle pulse, EX_ALU is new
//   EX_FLAGS    {carry, zero, negative}; present only with ALU_FLAGS_EN
//
// Build option: define ALU_FLAGS_EN to add EX_FLAGS.
// -----------------------------------------------------------------------------
interface alu_param_core_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  ACT;
    logic [3:0]            OP;
    logic [1:0]            MOVI;
    logic [DATA_WIDTH-1:0] REG_A;
    logic [DATA_WIDTH-1:0] REG_B;
    logic [DATA_WIDTH-1:0] MEM;
    logic [DATA_WIDTH-1:0] IMM;
    logic                  ALU_RDY;
    logic [DATA_WIDTH-1:0] EX_ALU;
    logic                  EX_ALU_VLD;
`ifdef ALU_FLAGS_EN
    logic [2:0]            EX_FLAGS;
`endif

    modport master (
`ifdef ALU_FLAGS_EN
        input  EX_FLAGS,
`endif
        output ACT, OP, MOVI, REG_A, REG_B, MEM, IMM,
        input  ALU_RDY, EX_ALU, EX_ALU_VLD
    );

    modport slave (
`ifdef ALU_FLAGS_EN
        output EX_FLAGS,
`endif
        input  ACT, OP, MOVI, REG_A, REG_B, MEM, IMM,
        output ALU_RDY, EX_ALU, EX_ALU_VLD
    );
endinterface

// File: rtl/alu_param_core.sv
// -----------------------------------------------------------------------------
// alu_param_core
// Parametrised 16-opcode ALU. Single-cycle ops give a result one cycle after
// the accept edge and keep the core ready, so back-to-back requests give one
// result per cycle. MULT is multicycle: the core goes busy for MUL_CYCLES
// cycles and then returns the low DATA_WIDTH bits of the product.
//
// Parameters:
//   DATA_WIDTH  operand/result width (>=2)
//   MUL_CYCLES  MULT latency in cycles (>=2)
//
// Ports:
//   CLK         clock, all state on the rising edge
//   RST         synchronous reset, active-high
//   bus         alu_param_core_if.slave (request fields, ALU_RDY, results)
//   fsm_state   debug view of the FSM state (0=IDLE, 1=MUL_BUSY)
//
// Build option: define ALU_FLAGS_EN to add EX_FLAGS {carry, zero, negative},
// which update together with EX_ALU.
// -----------------------------------------------------------------------------
module alu_param_core #(
    parameter int DATA_WIDTH = 8,
    parameter int MUL_CYCLES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    alu_param_core_if.slave  bus,
    output logic             fsm_state
);
    localparam int CNT_W = $clog2(MUL_CYCLES);

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MULT = 4'd2;
    localparam logic [3:0] OP_SHL  = 4'd3;
    localparam logic [3:0] OP_SHR  = 4'd4;
    localparam logic [3:0] OP_ROL  = 4'd5;
    localparam logic [3:0] OP_ROR  = 4'd6;
    localparam logic [3:0] OP_NOT  = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_OR   = 4'd9;
    localparam logic [3:0] OP_XOR  = 4'd10;
    localparam logic [3:0] OP_NAND = 4'd11;
    localparam logic [3:0] OP_NOR  = 4'd12;
    localparam logic [3:0] OP_XNOR = 4'd13;
    localparam logic [3:0] OP_INC  = 4'd14;
    localparam logic [3:0] OP_DEC  = 4'd15;

    typedef enum logic {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    live_q;     // low during reset, so ALU_RDY stays low
    logic [DATA_WIDTH-1:0]   res_q, res_d;
    logic                    vld_q, vld_d;
    logic [DATA_WIDTH-1:0]   mul_a_q, mul_a_d;
    logic [DATA_WIDTH-1:0]   mul_b_q, mul_b_d;
    logic                    carry_d;

    logic                    ready;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   opb;
    logic [DATA_WIDTH:0]     op_ext;     // {carry, result} of single-cycle ops
    logic [2*DATA_WIDTH-1:0] prod;

    assign ready  = (state_q == IDLE) && live_q;
    assign accept = bus.ACT && ready;

    always_comb begin
        case (bus.MOVI)
            2'd1:    opb = bus.MEM;
            2'd2:    opb = bus.IMM;
            default: opb = bus.REG_B;
        endcase
    end

    // Operands are zero-extended by one bit so the top bit of the sum or
    // difference is the carry-out or borrow.
    always_comb begin
        logic [DATA_WIDTH:0] ea;
        logic [DATA_WIDTH:0] eb;
        logic [DATA_WIDTH-1:0] a;
        a      = bus.REG_A;
        ea     = {1'b0, bus.REG_A};
        eb     = {1'b0, opb};
        op_ext = '0;
        case (bus.OP)
            OP_ADD:  op_ext = ea + eb;
            OP_SUB:  op_ext = ea - eb;
            OP_SHL:  op_ext = {a[DATA_WIDTH-1], a[DATA_WIDTH-2:0], 1'b0};
            OP_SHR:  op_ext = {a[0], 1'b0, a[DATA_WIDTH-1:1]};
            OP_ROL:  op_ext = {a[DATA_WIDTH-1], a[DATA_WIDTH-2:0], a[DATA_WIDTH-1]};
            OP_ROR:  op_ext = {a[0], a[0], a[DATA_WIDTH-1:1]};
            OP_NOT:  op_ext = {1'b0, ~a};
            OP_AND:  op_ext = {1'b0, a & opb};
            OP_OR:   op_ext = {1'b0, a | opb};
            OP_XOR:  op_ext = {1'b0, a ^ opb};
            OP_NAND: op_ext = {1'b0, ~(a & opb)};
            OP_NOR:  op_ext = {1'b0, ~(a | opb)};
            OP_XNOR: op_ext = {1'b0, ~(a ^ opb)};
            OP_INC:  op_ext = ea + (DATA_WIDTH+1)'(1);
            OP_DEC:  op_ext = ea - (DATA_WIDTH+1)'(1);
            default: op_ext = '0;   // MULT goes through the multicycle path
        endcase
    end

    assign prod = {{DATA_WIDTH{1'b0}}, mul_a_q} * {{DATA_WIDTH{1'b0}}, mul_b_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        vld_d   = 1'b0;
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        carry_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.OP == OP_MULT) begin
                        state_d = MUL_BUSY;
                        cnt_d   = CNT_W'(MUL_CYCLES - 1);
                        mul_a_d = bus.REG_A;
                        mul_b_d = opb;
                    end else begin
                        res_d   = op_ext[DATA_WIDTH-1:0];
                        carry_d = op_ext[DATA_WIDTH];
                        vld_d   = 1'b1;
                    end
                end
            end
            MUL_BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    res_d   = prod[DATA_WIDTH-1:0];
                    carry_d = |prod[2*DATA_WIDTH-1:DATA_WIDTH];
                    vld_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            mul_a_q <= '0;
            mul_b_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            live_q  <= 1'b1;
            res_q   <= res_d;
            vld_q   <= vld_d;
            mul_a_q <= mul_a_d;
            mul_b_q <= mul_b_d;
        end
    end

`ifdef ALU_FLAGS_EN
    logic [2:0] flags_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            flags_q <= 3'b000;
        end else if (vld_d) begin
            flags_q <= {carry_d, (res_d == '0), res_d[DATA_WIDTH-1]};
        end
    end

    assign bus.EX_FLAGS = flags_q;
`else
    logic unused_carry;
    assign unused_carry = carry_d;
`endif

    assign bus.ALU_RDY    = ready;
    assign bus.EX_ALU     = res_q;
    assign bus.EX_ALU_VLD = vld_q;
    assign fsm_state      = state_q;
endmodule
